// File: rtl/pipe_reg_elastic.sv
// Elastic register pipeline: DEPTH stages of WIDTH-bit data with valid/ready on both
// sides, bubble collapse, synchronous flush and a registered occupancy count.
module pipe_reg_elastic #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0] v;
  logic [WIDTH-1:0] d [DEPTH];
  logic [DEPTH-1:0] take;
  logic [DEPTH-1:0] move;
  logic [CW-1:0]    count_q;
  logic             in_xfer;
  logic             out_xfer;

  // Walk from the output end; a running term avoids reading take back into itself.
  always_comb begin
    logic t;
    take = '0;
    move = '0;
    t    = out_ready;
    for (int i = DEPTH-1; i >= 0; i--) begin
      move[i] = v[i] & t;
      take[i] = ~v[i] | move[i];
      t       = take[i];
    end
  end

  assign in_ready  = take[0] & ~flush;
  assign in_xfer   = in_valid & in_ready;
  assign out_valid = v[DEPTH-1];
  assign out_xfer  = v[DEPTH-1] & out_ready;
  assign out_data  = d[DEPTH-1];
  assign count     = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v       <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) d[i] <= RESET_VAL;
    end else if (flush) begin
      v       <= '0;
      count_q <= '0;
    end else begin
      if (take[0]) begin
        v[0] <= in_xfer;
        if (in_valid) d[0] <= in_data;
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (take[i]) v[i] <= move[i-1];
        if (move[i-1]) d[i] <= d[i-1];
      end
      count_q <= count_q + CW'(in_xfer) - CW'(out_xfer);
    end
  end

endmodule

// File: tb/tb_pipe_reg_elastic.sv
// Bench for pipe_reg_elastic: directed scenarios plus random traffic, all checked
// against a word-position model (each held word tracked by data and stage index).
module tb_pipe_reg_elastic;
  localparam int         WIDTH = 8;
  localparam int         DEPTH = 3;
  localparam logic [7:0] RV    = 8'hA5;
  localparam int         CW    = $clog2(DEPTH+1);

  logic          clk = 0, rst_n = 0;
  logic          in_valid = 0, out_ready = 0, flush = 0;
  logic [7:0]    in_data = 0;
  logic          in_ready, out_valid;
  logic [7:0]    out_data;
  logic [CW-1:0] count;

  int total = 0, bad = 0;

  logic [7:0] mdata[$];
  int         mpos[$];
  int         np[$];
  logic [7:0] mlast;

  always #5 clk = ~clk;

  pipe_reg_elastic #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VAL(RV)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .flush(flush), .count(count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic m_reset();
    mdata = {};
    mpos  = {};
    mlast = RV;
  endtask

  // Each word advances one stage per edge unless blocked by the word ahead;
  // the oldest word leaves from the last stage when the consumer is ready.
  task automatic m_plan();
    int lim, n;
    np = {};
    for (int k = 0; k < mpos.size(); k++) begin
      lim = (k == 0) ? (out_ready ? DEPTH : DEPTH-1) : np[k-1] - 1;
      n   = (mpos[k] + 1 < lim) ? mpos[k] + 1 : lim;
      np.push_back(n);
    end
  endtask

  function automatic bit m_in_ready();
    return !flush && (np.size() == 0 || np[np.size()-1] >= 1);
  endfunction

  task automatic m_step(input bit ir);
    if (flush) begin
      mdata = {};
      mpos  = {};
    end else begin
      for (int k = 0; k < mpos.size(); k++) mpos[k] = np[k];
      if (mpos.size() > 0 && mpos[0] == DEPTH) begin
        void'(mpos.pop_front());
        void'(mdata.pop_front());
      end
      if (in_valid && ir) begin
        mpos.push_back(0);
        mdata.push_back(in_data);
      end
      if (mpos.size() > 0 && mpos[0] == DEPTH-1) mlast = mdata[0];
    end
  endtask

  task automatic cycle(input logic iv, input logic [7:0] id, input logic ordy, input logic fl);
    bit exp_ir, exp_ov;
    @(negedge clk);
    in_valid = iv; in_data = id; out_ready = ordy; flush = fl;
    #1;
    m_plan();
    exp_ir = m_in_ready();
    exp_ov = (mpos.size() > 0 && mpos[0] == DEPTH-1);
    chk("in_ready", in_ready, exp_ir);
    chk("out_valid", out_valid, exp_ov);
    chk("out_data", out_data, mlast);
    chk("count", count, mdata.size());
    @(posedge clk);
    m_step(exp_ir);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH+1; i++) cycle(0, 8'h00, 1, 0);
  endtask

  initial begin
    m_reset();
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, RV);
    chk("rst_count", count, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1;

    // streaming
    for (int i = 0; i < 8; i++) begin
      cycle(1, 8'(i + 1), 1, 0);
      if (i == 2) begin
        #1;
        chk("stream_first", {out_valid, out_data}, {1'b1, 8'h01});
      end
    end
    drain();

    // backpressure then release
    cycle(1, 8'h10, 0, 0);
    cycle(1, 8'h11, 0, 0);
    cycle(1, 8'h12, 0, 0);
    cycle(1, 8'h13, 0, 0);
    cycle(1, 8'h13, 0, 0);
    #1;
    chk("bp_count", count, 3);
    chk("bp_hold", out_data, 8'h10);
    cycle(1, 8'h13, 1, 0);
    for (int i = 0; i < 5; i++) cycle(0, 8'h00, 1, 0);

    // bubble collapse
    cycle(1, 8'h20, 0, 0);
    cycle(0, 8'h00, 0, 0);
    cycle(0, 8'h00, 0, 0);
    cycle(1, 8'h21, 0, 0);
    cycle(0, 8'h00, 0, 0);
    #1;
    chk("bubble_count", count, 2);
    drain();

    // full pass-through
    cycle(1, 8'h30, 0, 0);
    cycle(1, 8'h31, 0, 0);
    cycle(1, 8'h32, 0, 0);
    cycle(1, 8'h33, 1, 0);
    #1;
    chk("pass_count", count, 3);
    drain();

    // flush with two words held
    cycle(1, 8'h40, 0, 0);
    cycle(1, 8'h41, 0, 0);
    cycle(1, 8'h42, 0, 1);
    cycle(0, 8'h00, 1, 0);

    // async reset while streaming
    for (int i = 0; i < 4; i++) cycle(1, 8'(8'h50 + i), 1, 0);
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_data", out_data, RV);
    chk("arst_count", count, 0);
    in_valid = 0; flush = 0;
    #1;
    chk("arst_in_ready", in_ready, 1);
    m_reset();
    @(negedge clk);
    rst_n = 1;

    // random traffic
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 9) < 6,
            $urandom_range(0, 99) < 3);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
